// File: rtl/gcd_sequencer_if.sv
// Operand/result handshake bundle between the IO wrapper (master) and gcd_sequencer (slave).
// Both directions use valid/ready; busy is a status sideband.
interface gcd_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd_out;
    logic             busy;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, gcd_out, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, gcd_out, busy
    );
endinterface

// File: rtl/gcd_sequencer.sv
// Subtractive GCD controller: result valid S+1 edges after accept (S = subtractions), held until out_ready.
// Accepts only in IDLE; optional iteration counter port under GCD_ITER_CNT_EN.
module gcd_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    gcd_sequencer_if.slave   bus
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [CNT_W-1:0] iter_cnt
`endif
);

    if (WIDTH < 2 || CNT_W < 1) begin : g_bad_param
        $error("gcd_sequencer: WIDTH must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] gcd_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.gcd_out   = gcd_r;
    assign bus.busy      = busy_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            gcd_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_r        <= bus.a_in;
                        b_r        <= bus.b_in;
                        state      <= CALC;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                CALC: begin
                    // Zero or equal operands terminate; otherwise shrink the larger one.
                    if (a_r == '0 || b_r == '0 || a_r == b_r) begin
                        gcd_r       <= (a_r == '0) ? b_r : a_r;
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else if (a_r > b_r) begin
                        a_r <= a_r - b_r;
                    end else begin
                        b_r <= b_r - a_r;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

`ifdef GCD_ITER_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cnt <= '0;
        end else if (state == IDLE && bus.in_valid && in_ready_r) begin
            iter_cnt <= '0;
        end else if (state == CALC && a_r != '0 && b_r != '0 && a_r != b_r
                     && iter_cnt != {CNT_W{1'b1}}) begin
            iter_cnt <= iter_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gcd_sequencer.sv
// Directed-vector bench for gcd_sequencer (WIDTH=8, CNT_W=8); build with +define+GCD_ITER_CNT_EN to cover iter_cnt.
module tb_gcd_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gcd_sequencer_if #(.WIDTH(8)) bus();

`ifdef GCD_ITER_CNT_EN
    logic [7:0] iter_cnt;
`endif

    gcd_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter_cnt (iter_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_iter(input string tag, input int exp);
`ifdef GCD_ITER_CNT_EN
        chk(tag, {24'd0, iter_cnt}, exp);
`endif
    endtask

    // Accept (a,b), wait for result, check latency/value, optionally hold out_ready low, then drain.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input logic [7:0] exp_g, input int exp_it,
                          input int hold);
        int n;
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        bus.a_in = a;
        bus.b_in = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a_in = 8'hA5;
        bus.b_in = 8'h3C;
        chk({tag, "_accepted"}, bus.in_ready, 0);
        n = 0;
        while (!bus.out_valid && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_gcd"}, bus.gcd_out, exp_g);
        chk({tag, "_busy_done"}, bus.busy, 1);
        chk_iter({tag, "_iter"}, exp_it);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold"}, {bus.out_valid, bus.in_ready, bus.gcd_out}, {1'b1, 1'b0, exp_g});
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_idle"}, {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
        chk({tag, "_gcd_kept"}, bus.gcd_out, exp_g);
    endtask

    initial begin
        int n;
        int k;
        int p;
        int acc[2];
        logic [7:0] results[$];
        logic [7:0] pa[2];
        logic [7:0] pb[2];

        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_state", {bus.in_ready, bus.out_valid, bus.busy, bus.gcd_out}, {3'b100, 8'd0});

        // Reset asserted mid-CALC
        bus.a_in = 8'd48;
        bus.b_in = 8'd18;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("mid_calc_rst", {bus.in_ready, bus.out_valid, bus.busy, bus.gcd_out}, {3'b100, 8'd0});
        chk_iter("mid_calc_rst_iter", 0);

        run_op("g48_18", 8'd48, 8'd18, 5, 8'd6, 4, 0);
        run_op("g12_8", 8'd12, 8'd8, 3, 8'd4, 2, 10);
        run_op("g0_5", 8'd0, 8'd5, 1, 8'd5, 0, 0);
        run_op("g9_0", 8'd9, 8'd0, 1, 8'd9, 0, 0);
        run_op("g7_7", 8'd7, 8'd7, 1, 8'd7, 0, 0);
        run_op("g0_0", 8'd0, 8'd0, 1, 8'd0, 0, 0);
        run_op("g255_1", 8'd255, 8'd1, 255, 8'd1, 254, 0);

        // New operands presented during CALC must wait for the next IDLE
        bus.a_in = 8'd21;
        bus.b_in = 8'd6;
        bus.in_valid = 1'b1;
        tick();
        bus.a_in = 8'd35;
        bus.b_in = 8'd14;
        n = 0;
        while (!bus.out_valid && n < 300) begin
            tick();
            n++;
        end
        chk("ign_lat1", n, 5);
        chk("ign_gcd1", bus.gcd_out, 8'd3);
        tick();
        chk("ign_done_hold", {bus.out_valid, bus.in_ready}, 2'b10);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("ign_idle", {bus.in_ready, bus.out_valid}, 2'b10);
        tick();
        bus.in_valid = 1'b0;
        chk("ign_accept2", bus.in_ready, 0);
        n = 0;
        while (!bus.out_valid && n < 300) begin
            tick();
            n++;
        end
        chk("ign_lat2", n, 4);
        chk("ign_gcd2", bus.gcd_out, 8'd7);
        bus.out_ready = 1'b1;
        tick();

        // Back-to-back with in_valid and out_ready held high
        pa[0] = 8'd100; pb[0] = 8'd75;
        pa[1] = 8'd17;  pb[1] = 8'd5;
        acc[0] = -1;
        acc[1] = -1;
        p = 0;
        for (k = 0; k < 40; k++) begin
            if (p < 2) begin
                bus.in_valid = 1'b1;
                bus.a_in = pa[p];
                bus.b_in = pb[p];
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.out_valid) results.push_back(bus.gcd_out);
            if (bus.in_valid && bus.in_ready) begin
                acc[p] = k;
                p++;
            end
            tick();
        end
        bus.out_ready = 1'b0;
        chk("b2b_count", results.size(), 2);
        chk("b2b_res0", (results.size() > 0) ? results[0] : 8'hFF, 8'd25);
        chk("b2b_res1", (results.size() > 1) ? results[1] : 8'hFF, 8'd1);
        chk("b2b_gap", acc[1] - acc[0], 6);
        chk("b2b_final_idle", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
        chk_iter("b2b_iter", 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
